regbank_mp: RTL and testbench
=============================

Name: regbank_mp

Overview:
- Parametrised multi-port register file for the pipelined RISC-V core.
- Provides 2 combinational read ports and 2 clocked write ports, one each for the ALU and load writebacks.
- Optional write-to-read bypass and hardwired-zero x0.
- A per-register busy scoreboard marks registers with an in-flight producer, so the issue stage can stall on RAW hazards.

Parameters:
- DATA_WIDTH, 32: width of each register and data port.
- NUM_REGS, 32: number of architectural registers (2..2^ADDR_W).
- ADDR_W, 5: register address width.
- ZERO_REG, 1: when 1, reg 0 reads as 0 and is never written or marked busy.
- BYPASS, 1: when 1, same-cycle write data is forwarded to matching reads.

Ports:
- clk_in, input, 1: clock; all state updates on the rising edge.
- rst_in, input, 1: asynchronous active-high reset.
- rd_addr_a, input, ADDR_W: read port A address.
- rd_addr_b, input, ADDR_W: read port B address.
- rd_data_a, output, DATA_WIDTH: read port A data (combinational).
- rd_data_b, output, DATA_WIDTH: read port B data (combinational).
- rd_busy_a, output, 1: register at rd_addr_a has a pending producer.
- rd_busy_b, output, 1: register at rd_addr_b has a pending producer.
- wr_en0, input, 1: write port 0 enable (ALU writeback).
- wr_addr0, input, ADDR_W: write port 0 address.
- wr_data0, input, DATA_WIDTH: write port 0 data.
- wr_en1, input, 1: write port 1 enable (load writeback).
- wr_addr1, input, ADDR_W: write port 1 address.
- wr_data1, input, DATA_WIDTH: write port 1 data.
- issue_en, input, 1: issue of an instruction with a destination register.
- issue_addr, input, ADDR_W: destination being claimed by that instruction.
- busy_vec, output, NUM_REGS: raw scoreboard bits, bit i = reg i busy.

Behaviour:
- Reset (rst_in=1, asynchronous):
  - all registers cleared to 0, all busy bits cleared.
  - so rd_data_*=0, rd_busy_*=0, busy_vec=0 while reset is held.
  - Reset asserted mid-write discards that write.
- Writes:
  - on posedge clk_in, if wr_enN=1 and wr_addrN<NUM_REGS then bank[wr_addrN] <= wr_dataN.
  - Latency 1 cycle: the new value is visible in the array the cycle after the edge.
  - Both ports to the same address in one cycle: port 1 wins and port 0's data is dropped.
  - ZERO_REG=1: any write to address 0 is ignored.
  - Address >= NUM_REGS: write ignored, no error.
- Reads (purely combinational; the same rules apply to port A and port B):
  - Address 0 with ZERO_REG=1 -> 0.
  - Address >= NUM_REGS -> 0.
  - BYPASS=1 and wr_en1 && wr_addr1==rd_addr -> wr_data1.
  - Otherwise, BYPASS=1 and wr_en0 && wr_addr0==rd_addr -> wr_data0.
  - Otherwise -> bank[rd_addr].
  - BYPASS=0: reads always return array contents, so a same-cycle write is seen one cycle later.
- Scoreboard (per register i, updated on posedge):
  - set = issue_en && issue_addr==i.
  - clr = (wr_en0 && wr_addr0==i) || (wr_en1 && wr_addr1==i).
  - set dominates clr: a new producer issuing in the same cycle as the old producer's writeback leaves busy=1.
  - clr with no set -> 0.
  - Otherwise the bit holds.
  - Reg 0 (ZERO_REG=1) and addresses >= NUM_REGS never set.
- rd_busy_x:
  - equals busy[rd_addr_x], masked to 0 when BYPASS=1 and a write to rd_addr_x is active this cycle (the forwarded value is valid).
  - Always 0 for addr 0 with ZERO_REG=1 and for out-of-range addresses.
- Issue of an already-busy register is legal (WAW): busy stays 1. The first writeback clears the bit; ordering is the pipeline's responsibility.
- No internal FSM beyond the array and the scoreboard; no combinational path from issue_* to rd_data_*.

Test Plan:
1. Reset and zero register:
   - Stimulus: pulse rst_in mid-cycle after loading x2=5.
   - Required: rd_data_a(x2)=0 and busy_vec=0 immediately (asynchronous).
   - Then write x0=0xDEAD and read x0.
   - Required: 0, and busy_vec[0] stays 0 after issue_addr=0.
2. Basic write/read, BYPASS=0:
   - Stimulus: wr_en0, x3=10.
   - Required: the same-cycle read of x3 is old value 0; the next cycle reads 10 on both ports.
3. Bypass and port collision, BYPASS=1:
   - Stimulus: wr_en0 x5=7 and wr_en1 x5=9 in the same cycle.
   - Required: rd_data_a(x5)=9 that cycle and 9 after the edge.
   - Stimulus: wr_en0 only, x6=4.
   - Required: same-cycle read returns 4.
4. Scoreboard lifecycle:
   - Stimulus: issue x1.
   - Required: rd_busy_a(x1)=1 from the next cycle.
   - Stimulus: writeback x1=15 on port 1.
   - Required: rd_busy_a=0 and data=15 in the writeback cycle (BYPASS=1); busy_vec[1]=0 afterwards.
5. Issue/writeback collision:
   - Stimulus: issue x4 and writeback x4=10 in the same cycle.
   - Required: x4=10 and busy_vec[4]=1 after the edge.
6. Out-of-range with NUM_REGS=16, ADDR_W=5:
   - Stimulus: write x20=3, read x20, issue x20.
   - Required: no array or scoreboard change; rd_data=0, rd_busy=0.

Source files
------------

// File: rtl/regbank_mp.sv
// regbank_mp: multi-port register file with a RAW busy scoreboard for the
// pipelined RISC-V core.
//
// Two combinational read ports (A, B) and two clocked write ports. Port 0
// carries the ALU writeback and port 1 the load writeback. Port 1 has priority
// when both write the same register in one cycle. When ZERO_REG is set, x0
// reads as zero and is never written or marked busy. When BYPASS is set, a
// write in progress this cycle is forwarded to a matching read.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   rd_addr_a/b             read addresses
//   rd_data_a/b             read data (combinational)
//   rd_busy_a/b             addressed register has a pending producer
//   wr_en0/wr_addr0/wr_data0  ALU writeback
//   wr_en1/wr_addr1/wr_data1  load writeback
//   issue_en/issue_addr     destination claimed by an issuing instruction
//   busy_vec                raw scoreboard, bit i = register i busy
module regbank_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_W     = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_busy_a,
    output logic                  rd_busy_b,
    input  logic                  wr_en0,
    input  logic [ADDR_W-1:0]     wr_addr0,
    input  logic [DATA_WIDTH-1:0] wr_data0,
    input  logic                  wr_en1,
    input  logic [ADDR_W-1:0]     wr_addr1,
    input  logic [DATA_WIDTH-1:0] wr_data1,
    input  logic                  issue_en,
    input  logic [ADDR_W-1:0]     issue_addr,
    output logic [NUM_REGS-1:0]   busy_vec
);

    // The whole address space is populated so reads can index with the full
    // address width; entries that do not hold a live register read as zero.
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_WIDTH-1:0] bank_data [DEPTH];
    logic [DEPTH-1:0]      busy_all;

    genvar gi;

    // One storage slot plus scoreboard bit per architectural register.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi < NUM_REGS && !(ZERO_REG != 0 && gi == 0)) begin : g_live
                logic [DATA_WIDTH-1:0] value_reg;
                logic                  busy_reg;
                logic                  wr0_hit;
                logic                  wr1_hit;
                logic                  set_hit;

                assign wr0_hit = wr_en0 && (wr_addr0 == ADDR_W'(gi));
                assign wr1_hit = wr_en1 && (wr_addr1 == ADDR_W'(gi));
                assign set_hit = issue_en && (issue_addr == ADDR_W'(gi));

                always_ff @(posedge clk_in or posedge rst_in) begin
                    if (rst_in) begin
                        value_reg <= '0;
                        busy_reg  <= 1'b0;
                    end else begin
                        if (wr1_hit) begin
                            value_reg <= wr_data1;
                        end else if (wr0_hit) begin
                            value_reg <= wr_data0;
                        end
                        // A new producer issuing in the same cycle as the old
                        // producer's writeback keeps the register busy.
                        if (set_hit) begin
                            busy_reg <= 1'b1;
                        end else if (wr0_hit || wr1_hit) begin
                            busy_reg <= 1'b0;
                        end
                    end
                end

                assign bank_data[gi] = value_reg;
                assign busy_all[gi]  = busy_reg;
            end else begin : g_dead
                assign bank_data[gi] = '0;
                assign busy_all[gi]  = 1'b0;
            end
        end
    endgenerate

    assign busy_vec = busy_all[NUM_REGS-1:0];

    // Read ports: identical logic for A (index 0) and B (index 1).
    logic [ADDR_W-1:0] rd_addr_p [2];

    assign rd_addr_p[0] = rd_addr_a;
    assign rd_addr_p[1] = rd_addr_b;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic                  in_range;
            logic                  is_zero;
            logic                  hit0;
            logic                  hit1;
            logic [DATA_WIDTH-1:0] rd_value;
            logic                  rd_busy;

            assign in_range = {1'b0, rd_addr_p[gi]} < (ADDR_W + 1)'(NUM_REGS);
            assign is_zero  = (ZERO_REG != 0) && (rd_addr_p[gi] == '0);
            assign hit1     = (BYPASS != 0) && wr_en1 && (wr_addr1 == rd_addr_p[gi]);
            assign hit0     = (BYPASS != 0) && wr_en0 && (wr_addr0 == rd_addr_p[gi]);

            always_comb begin
                rd_value = bank_data[rd_addr_p[gi]];
                rd_busy  = busy_all[rd_addr_p[gi]];
                if (rst_in || is_zero || !in_range) begin
                    // Reset gating keeps reads at zero while reset is held,
                    // even if a forwardable write is present.
                    rd_value = '0;
                    rd_busy  = 1'b0;
                end else if (hit1) begin
                    rd_value = wr_data1;
                    rd_busy  = 1'b0;
                end else if (hit0) begin
                    rd_value = wr_data0;
                    rd_busy  = 1'b0;
                end
            end
        end
    endgenerate

    assign rd_data_a = g_rd[0].rd_value;
    assign rd_data_b = g_rd[1].rd_value;
    assign rd_busy_a = g_rd[0].rd_busy;
    assign rd_busy_b = g_rd[1].rd_busy;

endmodule

// File: tb/tb_regbank_mp.sv
// Testbench for regbank_mp. Two instances share the stimulus: instance 0 uses
// the default configuration (32 registers, bypass on) and instance 1 uses 16
// registers with bypass off. Expected outputs are pushed into a queue by the
// stimulus and popped and compared by a separate monitor on the falling edge.
module tb_regbank_mp;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [4:0]  rd_addr_a = '0, rd_addr_b = '0;
    logic        wr_en0 = 1'b0, wr_en1 = 1'b0, issue_en = 1'b0;
    logic [4:0]  wr_addr0 = '0, wr_addr1 = '0, issue_addr = '0;
    logic [31:0] wr_data0 = '0, wr_data1 = '0;

    logic [31:0] rd_data_a0, rd_data_b0, rd_data_a1, rd_data_b1;
    logic        rd_busy_a0, rd_busy_b0, rd_busy_a1, rd_busy_b1;
    logic [31:0] busy_vec0;
    logic [15:0] busy_vec1;

    always #5 clk_in = ~clk_in;

    regbank_mp u_dut0 (
        .clk_in(clk_in), .rst_in(rst_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a0), .rd_data_b(rd_data_b0),
        .rd_busy_a(rd_busy_a0), .rd_busy_b(rd_busy_b0),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_vec(busy_vec0)
    );

    regbank_mp #(.NUM_REGS(16), .BYPASS(0)) u_dut1 (
        .clk_in(clk_in), .rst_in(rst_in),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a1), .rd_data_b(rd_data_b1),
        .rd_busy_a(rd_busy_a1), .rd_busy_b(rd_busy_b1),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .busy_vec(busy_vec1)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_bank [2][32];
    bit          m_busy [2][32];

    function automatic int nregs(input int i);
        return (i == 0) ? 32 : 16;
    endfunction

    function automatic bit byp(input int i);
        return (i == 0);
    endfunction

    function automatic bit live(input int i, input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < nregs(i));
    endfunction

    function automatic logic [31:0] exp_data(input int i, input logic [4:0] a);
        if (rst_in || !live(i, a)) return 32'd0;
        if (byp(i) && wr_en1 && wr_addr1 == a) return wr_data1;
        if (byp(i) && wr_en0 && wr_addr0 == a) return wr_data0;
        return m_bank[i][a];
    endfunction

    function automatic logic exp_busy(input int i, input logic [4:0] a);
        if (rst_in || !live(i, a)) return 1'b0;
        if (byp(i) && ((wr_en1 && wr_addr1 == a) || (wr_en0 && wr_addr0 == a))) return 1'b0;
        return m_busy[i][a];
    endfunction

    function automatic logic [31:0] exp_vec(input int i);
        logic [31:0] v = '0;
        for (int r = 0; r < 32; r++) v[r] = m_busy[i][r];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 32; r++) begin
                m_bank[i][r] = '0;
                m_busy[i][r] = 1'b0;
            end
    endtask

    // Apply one clock edge's worth of architectural effect to the model.
    task automatic model_commit();
        for (int i = 0; i < 2; i++) begin
            if (wr_en0 && live(i, wr_addr0)) begin
                m_bank[i][wr_addr0] = wr_data0;
                m_busy[i][wr_addr0] = 1'b0;
            end
            if (wr_en1 && live(i, wr_addr1)) begin
                m_bank[i][wr_addr1] = wr_data1;
                m_busy[i][wr_addr1] = 1'b0;
            end
            if (issue_en && live(i, issue_addr)) m_busy[i][issue_addr] = 1'b1;
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] da0, db0, da1, db1, bv0, bv1;
        logic        ba0, bb0, ba1, bb1;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic push_expected();
        exp_t e;
        e.da0 = exp_data(0, rd_addr_a);
        e.db0 = exp_data(0, rd_addr_b);
        e.da1 = exp_data(1, rd_addr_a);
        e.db1 = exp_data(1, rd_addr_b);
        e.ba0 = exp_busy(0, rd_addr_a);
        e.bb0 = exp_busy(0, rd_addr_b);
        e.ba1 = exp_busy(1, rd_addr_a);
        e.bb1 = exp_busy(1, rd_addr_b);
        e.bv0 = exp_vec(0);
        e.bv1 = exp_vec(1);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("i0_data_a", rd_data_a0, e.da0);
                chk("i0_data_b", rd_data_b0, e.db0);
                chk("i0_busy_a", {31'd0, rd_busy_a0}, {31'd0, e.ba0});
                chk("i0_busy_b", {31'd0, rd_busy_b0}, {31'd0, e.bb0});
                chk("i0_busy_vec", busy_vec0, e.bv0);
                chk("i1_data_a", rd_data_a1, e.da1);
                chk("i1_data_b", rd_data_b1, e.db1);
                chk("i1_busy_a", {31'd0, rd_busy_a1}, {31'd0, e.ba1});
                chk("i1_busy_b", {31'd0, rd_busy_b1}, {31'd0, e.bb1});
                chk("i1_busy_vec", {16'd0, busy_vec1}, e.bv1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic we0, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic we1, input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic ie, input logic [4:0] ia,
                        input logic [4:0] ra, input logic [4:0] rb);
        wr_en0 = we0; wr_addr0 = wa0; wr_data0 = wd0;
        wr_en1 = we1; wr_addr1 = wa1; wr_data1 = wd1;
        issue_en = ie; issue_addr = ia;
        rd_addr_a = ra; rd_addr_b = rb;
        push_expected();
        @(posedge clk_in);
        model_commit();
        #1;
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ra, rb);
    endtask

    // Assert reset in the middle of a cycle, check while held, release before the edge.
    task automatic reset_cycle(input logic [4:0] ra, input logic [4:0] rb);
        wr_en0 = 1'b0; wr_en1 = 1'b0; issue_en = 1'b0;
        rd_addr_a = ra; rd_addr_b = rb;
        rst_in = 1'b1;
        #1;
        model_clear();
        push_expected();
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        @(posedge clk_in);
        model_commit();
        #1;
    endtask

    initial begin : stimulus
        model_clear();
        @(posedge clk_in);
        #1;
        reset_cycle(5'd2, 5'd0);

        // Reset and zero register
        step(1'b1, 5'd2, 32'd5, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd2, 5'd7);
        idle(5'd2, 5'd7);
        reset_cycle(5'd2, 5'd7);
        step(1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd2);

        // Basic write/read (instance 1 has no bypass)
        step(1'b1, 5'd3, 32'd10, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
        idle(5'd3, 5'd3);

        // Port collision and bypass
        step(1'b1, 5'd5, 32'd7, 1'b1, 5'd5, 32'd9, 1'b0, 5'd0, 5'd5, 5'd5);
        idle(5'd5, 5'd5);
        step(1'b1, 5'd6, 32'd4, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd5);

        // Scoreboard lifecycle
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 5'd1, 5'd6);
        idle(5'd1, 5'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd1, 32'd15, 1'b0, 5'd0, 5'd1, 5'd1);
        idle(5'd1, 5'd1);

        // Issue/writeback collision
        step(1'b1, 5'd4, 32'd10, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd1);
        idle(5'd4, 5'd4);

        // Out of range for the 16-register instance
        step(1'b1, 5'd20, 32'd3, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 5'd20, 5'd20);
        idle(5'd20, 5'd20);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if (n == 150) reset_cycle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Drain the scoreboard within a bounded number of cycles.
        repeat (3) @(posedge clk_in);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
